glyph_row_scheduler: RTL and testbench

Time-multiplexes one synchronous single-port 16x16 glyph ROM among the nine digit positions of the RGB value display: R, G and B channels, each with hundreds, tens and units digits. One `start` pulse per display scanline makes the block do three things:
- latch the nine digit codes and the glyph row index;
- fetch the nine 16-bit glyph rows in a fixed order into a shadow bank;
- publish all nine rows together to the pixel serializer.

The block sits between the value-to-BCD logic and the VGA pixel path. It replaces nine parallel ROM read ports with one.

---
 rtl/glyph_pkg.sv | 54 +++++
 rtl/glyph_row_bank.sv | 51 +++++
 rtl/glyph_row_scheduler.sv | 129 ++++++++++++
 tb/tb_glyph_row_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared widths, digit indices, FSM encoding and helpers for the glyph row scheduler.
// Optional leading-zero blanking is controlled by GLYPH_LEADING_ZERO_BLANK_EN.
package glyph_pkg;

    localparam int NUM_DIGITS = 9;
    localparam int GLYPH_W    = 16;
    localparam int CODE_W     = 4;
    localparam int ROW_W      = 4;
    localparam int IDX_W      = 4;
    localparam int CODES_W    = NUM_DIGITS * CODE_W;
    localparam int ROWS_W     = NUM_DIGITS * GLYPH_W;

    localparam int IDX_R_H = 0;
    localparam int IDX_R_D = 1;
    localparam int IDX_R_U = 2;
    localparam int IDX_G_H = 3;
    localparam int IDX_G_D = 4;
    localparam int IDX_G_U = 5;
    localparam int IDX_B_H = 6;
    localparam int IDX_B_D = 7;
    localparam int IDX_B_U = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic logic [CODE_W-1:0] code_at(input logic [CODES_W-1:0] codes,
                                                  input logic [IDX_W-1:0] idx);
        logic [CODE_W-1:0] val;
        val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) val = codes[i*CODE_W +: CODE_W];
        end
        return val;
    endfunction

    // Hundreds blanked when zero; tens blanked only if hundreds is also zero.
    function automatic logic [ROWS_W-1:0] blank_leading_zeros(input logic [ROWS_W-1:0] rows,
                                                              input logic [CODES_W-1:0] codes);
        logic [ROWS_W-1:0] res;
        res = rows;
        for (int ch = 0; ch < 3; ch++) begin
            if (codes[(3*ch)*CODE_W +: CODE_W] == '0) begin
                res[(3*ch)*GLYPH_W +: GLYPH_W] = '0;
                if (codes[(3*ch+1)*CODE_W +: CODE_W] == '0) begin
                    res[(3*ch+1)*GLYPH_W +: GLYPH_W] = '0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/glyph_row_bank.sv
// Shadow/visible glyph row storage: ROM captures into shadow, swap publishes all nine at once.
// With GLYPH_LEADING_ZERO_BLANK_EN defined, leading-zero rows are blanked at the swap.
module glyph_row_bank
    import glyph_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                cap_en,
    input  logic [IDX_W-1:0]    cap_idx,
    input  logic [GLYPH_W-1:0]  cap_data,
    input  logic                swap,
`ifdef GLYPH_LEADING_ZERO_BLANK_EN
    input  logic [CODES_W-1:0]  codes,
`endif
    output logic [ROWS_W-1:0]   rows_out
);

    logic [ROWS_W-1:0] shadow_q, shadow_d;
    logic [ROWS_W-1:0] rows_q, rows_d;

    // The last capture and the swap share an edge, so the swap takes shadow_d.
    always_comb begin
        shadow_d = shadow_q;
        if (cap_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_idx == IDX_W'(i)) shadow_d[i*GLYPH_W +: GLYPH_W] = cap_data;
            end
        end
        rows_d = rows_q;
        if (swap) begin
`ifdef GLYPH_LEADING_ZERO_BLANK_EN
            rows_d = blank_leading_zeros(shadow_d, codes);
`else
            rows_d = shadow_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shadow_q <= '0;
            rows_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            rows_q   <= rows_d;
        end
    end

    assign rows_out = rows_q;

endmodule

// File: rtl/glyph_row_scheduler.sv
// Shares one synchronous glyph ROM among nine display digits, one fetch per start pulse.
// Optional leading-zero blanking via GLYPH_LEADING_ZERO_BLANK_EN (applied in glyph_row_bank).
module glyph_row_scheduler
    import glyph_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [ROW_W-1:0]    row,
    input  logic [CODES_W-1:0]  codes,
    output logic                rom_en,
    output logic [CODE_W-1:0]   rom_code,
    output logic [ROW_W-1:0]    rom_row,
    input  logic [GLYPH_W-1:0]  rom_data,
    output logic [ROWS_W-1:0]   rows_out,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [CODES_W-1:0]   codes_q, codes_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 rom_en_q, rom_en_d;
    logic [CODE_W-1:0]    rom_code_q, rom_code_d;
    logic [ROW_W-1:0]     rom_row_q, rom_row_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic                 cap_en_q, cap_en_d;
    logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
    logic                 swap;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        codes_d    = codes_q;
        row_d      = row_q;
        rom_en_d   = 1'b0;
        rom_code_d = rom_code_q;
        rom_row_d  = rom_row_q;
        done_d     = 1'b0;
        overrun_d  = start && (state_q != ST_IDLE);
        // ROM data for the index issued this cycle arrives next cycle.
        cap_en_d   = rom_en_q;
        cap_idx_d  = k_q;
        swap       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    codes_d    = codes;
                    row_d      = row;
                    k_d        = '0;
                    rom_en_d   = 1'b1;
                    rom_code_d = codes[CODE_W-1:0];
                    rom_row_d  = row;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (k_q == IDX_W'(NUM_DIGITS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d        = k_q + 1'b1;
                    rom_en_d   = 1'b1;
                    rom_code_d = code_at(codes_q, k_q + 1'b1);
                end
            end
            ST_DRAIN: begin
                swap    = 1'b1;
                done_d  = 1'b1;
                k_d     = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            codes_q    <= '0;
            row_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_code_q <= '0;
            rom_row_q  <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            codes_q    <= codes_d;
            row_q      <= row_d;
            rom_en_q   <= rom_en_d;
            rom_code_q <= rom_code_d;
            rom_row_q  <= rom_row_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            cap_en_q   <= cap_en_d;
            cap_idx_q  <= cap_idx_d;
        end
    end

    glyph_row_bank u_bank (
        .clk      (clk),
        .clr      (clr),
        .cap_en   (cap_en_q),
        .cap_idx  (cap_idx_q),
        .cap_data (rom_data),
        .swap     (swap),
`ifdef GLYPH_LEADING_ZERO_BLANK_EN
        .codes    (codes_q),
`endif
        .rows_out (rows_out)
    );

    assign rom_en   = rom_en_q;
    assign rom_code = rom_code_q;
    assign rom_row  = rom_row_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_glyph_row_scheduler.sv
// Self-checking bench for glyph_row_scheduler against a table-driven ROM and row model.
module tb_glyph_row_scheduler;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [3:0]   row;
    logic [35:0]  codes;
    logic         rom_en;
    logic [3:0]   rom_code;
    logic [3:0]   rom_row;
    logic [15:0]  rom_data;
    logic [143:0] rows_out;
    logic         busy;
    logic         done;
    logic         overrun;

    logic [15:0]  mem [16][16];
    int checks = 0;
    int passes = 0;

    glyph_row_scheduler dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .row      (row),
        .codes    (codes),
        .rom_en   (rom_en),
        .rom_code (rom_code),
        .rom_row  (rom_row),
        .rom_data (rom_data),
        .rows_out (rows_out),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous single-port ROM: data one cycle after the strobe.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_code][rom_row];
    end

    function automatic logic [143:0] expect_rows(input logic [35:0] c, input logic [3:0] r);
        logic [143:0] res;
        logic [3:0]   dig [9];
        for (int k = 0; k < 9; k++) begin
            dig[k] = c[k*4 +: 4];
            res[k*16 +: 16] = mem[dig[k]][r];
        end
`ifdef GLYPH_LEADING_ZERO_BLANK_EN
        for (int ch = 0; ch < 3; ch++) begin
            if (dig[3*ch] == 4'd0) begin
                res[48*ch +: 16] = 16'h0;
                if (dig[3*ch+1] == 4'd0) res[48*ch+16 +: 16] = 16'h0;
            end
        end
`endif
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom_random;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                mem[a][b] = 16'($urandom) | 16'h0001;
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b0; codes = '0; row = '0;
        tick; tick;
        checks++;
        if ({rom_en, busy, done, overrun} !== 4'b0000)
            $display("FAIL reset_ctrl got %b want 0000", {rom_en, busy, done, overrun});
        else passes++;
        checks++;
        if ({rom_code, rom_row} !== 8'h00)
            $display("FAIL reset_rom_sel got %h want 00", {rom_code, rom_row});
        else passes++;
        checks++;
        if (rows_out !== 144'h0) $display("FAIL reset_rows got %h want 0", rows_out);
        else passes++;
        clr = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [3:0] exp_v;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                mem[a][b] = 16'h1FF8;
        codes = '0; row = 4'd0; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            start = 1'b0;
            exp_v = {c <= 9, c <= 10, c == 11, 1'b0};
            checks++;
            if ({rom_en, busy, done, overrun} !== exp_v)
                $display("FAIL basic_ctrl cyc %0d got %b want %b", c,
                         {rom_en, busy, done, overrun}, exp_v);
            else passes++;
            if (c <= 9) begin
                checks++;
                if ({rom_code, rom_row} !== 8'h00)
                    $display("FAIL basic_sel cyc %0d got %h want 00", c, {rom_code, rom_row});
                else passes++;
            end
            if (c == 11) begin
                checks++;
                if (rows_out !== {9{16'h1FF8}})
                    $display("FAIL basic_rows got %h want %h", rows_out, {9{16'h1FF8}});
                else passes++;
            end
        end
    endtask

    task automatic test_random;
        logic [35:0]  c1;
        logic [3:0]   r1;
        logic [143:0] exp_rows;
        fill_rom_random;
        for (int it = 0; it < 6; it++) begin
            c1 = {4'($urandom), 32'($urandom)};
            r1 = 4'($urandom);
            codes = c1; row = r1; start = 1'b1;
            for (int c = 1; c <= 11; c++) begin
                tick;
                start = 1'b0;
                codes = {4'($urandom), 32'($urandom)};
                row = 4'($urandom);
                if (c <= 9) begin
                    checks++;
                    if ({rom_en, rom_code, rom_row} !== {1'b1, c1[(c-1)*4 +: 4], r1})
                        $display("FAIL rand_issue it %0d cyc %0d got %h want %h", it, c,
                                 {rom_en, rom_code, rom_row}, {1'b1, c1[(c-1)*4 +: 4], r1});
                    else passes++;
                end
                if (c == 10) begin
                    checks++;
                    if ({rom_en, busy, rom_code} !== {2'b01, c1[35:32]})
                        $display("FAIL rand_hold it %0d got %h want %h", it,
                                 {rom_en, busy, rom_code}, {2'b01, c1[35:32]});
                    else passes++;
                end
            end
            exp_rows = expect_rows(c1, r1);
            checks++;
            if ({done, rows_out} !== {1'b1, exp_rows})
                $display("FAIL rand_rows it %0d done %b got %h want %h", it, done, rows_out,
                         exp_rows);
            else passes++;
        end
    endtask

    task automatic test_overrun;
        logic [35:0]  c1;
        logic [3:0]   r1;
        logic [3:0]   exp_v;
        logic [143:0] exp_rows;
        fill_rom_random;
        c1 = {4'($urandom), 32'($urandom)};
        r1 = 4'($urandom);
        exp_rows = expect_rows(c1, r1);
        codes = c1; row = r1; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick;
            start = 1'b0;
            exp_v = {c <= 9, c <= 10, c == 11, c == 5};
            checks++;
            if ({rom_en, busy, done, overrun} !== exp_v)
                $display("FAIL overrun_ctrl cyc %0d got %b want %b", c,
                         {rom_en, busy, done, overrun}, exp_v);
            else passes++;
            if (c == 11) begin
                checks++;
                if (rows_out !== exp_rows)
                    $display("FAIL overrun_rows got %h want %h", rows_out, exp_rows);
                else passes++;
            end
            if (c == 4) begin
                start = 1'b1;
                codes = ~c1;
                row = ~r1;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [35:0]  c1, c2;
        logic [3:0]   r1;
        logic [3:0]   exp_v;
        logic [143:0] e1, e2;
        fill_rom_random;
        c1 = {4'($urandom), 32'($urandom)};
        c2 = {4'($urandom), 32'($urandom)};
        r1 = 4'($urandom);
        e1 = expect_rows(c1, r1);
        e2 = expect_rows(c2, 4'd5);
        codes = c1; row = r1; start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick;
            start = 1'b0;
            exp_v = {(c <= 9) || (c >= 12 && c <= 20), (c <= 10) || (c >= 12 && c <= 21),
                     (c == 11) || (c == 22), 1'b0};
            checks++;
            if ({rom_en, busy, done, overrun} !== exp_v)
                $display("FAIL b2b_ctrl cyc %0d got %b want %b", c,
                         {rom_en, busy, done, overrun}, exp_v);
            else passes++;
            if (c >= 12 && c <= 20) begin
                checks++;
                if ({rom_code, rom_row} !== {c2[(c-12)*4 +: 4], 4'd5})
                    $display("FAIL b2b_sel cyc %0d got %h want %h", c, {rom_code, rom_row},
                             {c2[(c-12)*4 +: 4], 4'd5});
                else passes++;
            end
            if (c == 11 || c == 21) begin
                checks++;
                if (rows_out !== e1) $display("FAIL b2b_rows1 cyc %0d got %h want %h", c,
                                              rows_out, e1);
                else passes++;
            end
            if (c == 22) begin
                checks++;
                if (rows_out !== e2) $display("FAIL b2b_rows2 got %h want %h", rows_out, e2);
                else passes++;
            end
            if (c == 11) begin
                codes = c2; row = 4'd5; start = 1'b1;
            end
        end
    endtask

    task automatic test_blanking;
        logic [35:0]  c1;
        logic [3:0]   r1;
        logic [143:0] exp_rows;
        fill_rom_random;
        r1 = 4'($urandom);
        c1 = {12'($urandom), 4'd0, 4'd5, 4'd0, 4'd7, 4'd0, 4'd0};
        exp_rows = expect_rows(c1, r1);
        codes = c1; row = r1; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick;
            start = 1'b0;
        end
        checks++;
        if ({done, rows_out} !== {1'b1, exp_rows})
            $display("FAIL blank_rows done %b got %h want %h", done, rows_out, exp_rows);
        else passes++;
        checks++;
        if (rows_out[2*16 +: 16] !== mem[7][r1] || rows_out[4*16 +: 16] !== mem[5][r1] ||
            rows_out[5*16 +: 16] !== mem[0][r1])
            $display("FAIL blank_units got %h want %h_%h_%h", rows_out[95:32], mem[0][r1],
                     mem[5][r1], mem[7][r1]);
        else passes++;
    endtask

    task automatic test_mid_reset;
        logic [35:0]  c1;
        logic [3:0]   r1;
        logic [143:0] exp_rows;
        c1 = {4'($urandom), 32'($urandom)};
        r1 = 4'($urandom);
        codes = c1; row = r1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick;
            start = 1'b0;
        end
        checks++;
        if ({rom_en, busy} !== 2'b11) $display("FAIL midrst_pre got %b want 11", {rom_en, busy});
        else passes++;
        clr = 1'b1;
        #1;
        checks++;
        if ({rom_en, busy, done, overrun, rom_code, rom_row} !== 12'h000 || rows_out !== '0)
            $display("FAIL midrst_clear got %h rows %h want 000 rows 0",
                     {rom_en, busy, done, overrun, rom_code, rom_row}, rows_out);
        else passes++;
        tick;
        clr = 1'b0;
        c1 = {4'($urandom), 32'($urandom)};
        r1 = 4'($urandom);
        exp_rows = expect_rows(c1, r1);
        codes = c1; row = r1; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick;
            start = 1'b0;
            if (c == 10) begin
                checks++;
                if (done !== 1'b0) $display("FAIL midrst_early_done got %b want 0", done);
                else passes++;
            end
        end
        checks++;
        if ({done, rows_out} !== {1'b1, exp_rows})
            $display("FAIL midrst_rows done %b got %h want %h", done, rows_out, exp_rows);
        else passes++;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; codes = '0; row = '0;
        test_reset;
        test_basic;
        test_random;
        test_overrun;
        test_back_to_back;
        test_blanking;
        test_mid_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
